// File: rtl/audio_nios_pio_pkg.sv
// audio_nios_pio_pkg: register map constants and read-word helper shared by the LED PIO files
package audio_nios_pio_pkg;
  localparam int ADDR_W = 3;
  localparam logic [ADDR_W-1:0] ADDR_DATA       = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_BLINK_MASK = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS     = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET     = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR   = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_OUTTOGGLE  = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_OUTPORT    = 3'd7;
  function automatic logic [31:0] rd_word(input logic [31:0] v, input int unsigned w);
    return w >= 32 ? v : v & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/audio_nios_pio_led_blink_if.sv
// audio_nios_pio_led_blink_if: Avalon-MM slave bundle for the LED PIO
interface audio_nios_pio_led_blink_if;
  import audio_nios_pio_pkg::*;
  logic [ADDR_W-1:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/audio_nios_pio_blink_timer.sv
// audio_nios_pio_blink_timer: free-running half-period counter that toggles the blink phase on wrap
module audio_nios_pio_blink_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clr_cnt,
  input  logic                clr_all,
  output logic                phase
);
  logic [PERIOD_W-1:0] cnt_d, cnt_q;
  logic phase_d, phase_q, wrap;
  // a period write restarts the count without toggling; a status write also zeroes the phase
  always_comb begin
    wrap    = cnt_q == period;
    cnt_d   = (clr_cnt || clr_all || wrap) ? '0 : cnt_q + 1'b1;
    phase_d = clr_all ? 1'b0 : (wrap && !clr_cnt) ? !phase_q : phase_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end
  assign phase = phase_q;
endmodule

// File: rtl/audio_nios_pio_led_blink.sv
// audio_nios_pio_led_blink: Avalon-MM output PIO with set/clear/toggle, readback and optional
// per-bit blink engine enabled by AUDIO_NIOS_PIO_LED_BLINK_EN
module audio_nios_pio_led_blink
  import audio_nios_pio_pkg::*;
#(
  parameter int               WIDTH       = 26,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PERIOD_W    = 24
) (
  input  logic                        clk,
  input  logic                        reset_n,
  audio_nios_pio_led_blink_if.slave   bus,
  output logic [WIDTH-1:0]            out_port
);
  logic we;
  logic [WIDTH-1:0] wd, data_d, data_q;
  assign we = bus.chipselect && !bus.write_n;
  assign wd = bus.writedata[WIDTH-1:0];
  always_comb begin
    data_d = !we                             ? data_q :
             bus.address == ADDR_DATA        ? wd :
             bus.address == ADDR_OUTSET      ? data_q | wd :
             bus.address == ADDR_OUTCLEAR    ? data_q & ~wd :
             bus.address == ADDR_OUTTOGGLE   ? data_q ^ wd : data_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= RESET_VALUE;
    else data_q <= data_d;
  end
`ifdef AUDIO_NIOS_PIO_LED_BLINK_EN
  logic [WIDTH-1:0] mask_d, mask_q;
  logic [PERIOD_W-1:0] period_d, period_q;
  logic phase, clr_cnt, clr_all;
  always_comb begin
    clr_cnt  = we && bus.address == ADDR_PERIOD;
    clr_all  = we && bus.address == ADDR_STATUS;
    mask_d   = (we && bus.address == ADDR_BLINK_MASK) ? wd : mask_q;
    period_d = clr_cnt ? bus.writedata[PERIOD_W-1:0] : period_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      period_q <= '1;
    end else begin
      mask_q   <= mask_d;
      period_q <= period_d;
    end
  end
  audio_nios_pio_blink_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_q),
    .clr_cnt (clr_cnt),
    .clr_all (clr_all),
    .phase   (phase)
  );
  assign out_port = data_q & ~(mask_q & {WIDTH{phase}});
`else
  assign out_port = data_q;
`endif
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:       bus.readdata = rd_word(32'(data_q), WIDTH);
`ifdef AUDIO_NIOS_PIO_LED_BLINK_EN
      ADDR_BLINK_MASK: bus.readdata = rd_word(32'(mask_q), WIDTH);
      ADDR_PERIOD:     bus.readdata = rd_word(32'(period_q), PERIOD_W);
      ADDR_STATUS:     bus.readdata = {31'd0, phase};
`endif
      ADDR_OUTPORT:    bus.readdata = rd_word(32'(out_port), WIDTH);
      default:         bus.readdata = '0;
    endcase
  end
endmodule

// File: tb/tb_audio_nios_pio_led_blink.sv
// tb_audio_nios_pio_led_blink: random and directed bus traffic checked against a time-based blink model
`timescale 1ns/1ps
module tb_audio_nios_pio_led_blink;
  import audio_nios_pio_pkg::*;
`ifdef AUDIO_NIOS_PIO_LED_BLINK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam logic [31:0] WM = 32'h03FF_FFFF;
  localparam logic [31:0] PM = 32'h00FF_FFFF;
  localparam logic [31:0] RV = 32'h0000_00A5;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [25:0] out_port;
  audio_nios_pio_led_blink_if bus();
  audio_nios_pio_led_blink #(.WIDTH(26), .RESET_VALUE(26'h00000A5), .PERIOD_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .out_port(out_port)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  longint n = 0, anc = 0;
  bit anc_ph;
  logic [31:0] m_data, m_mask, m_per;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // phase after k edges = anchor phase flipped once per completed (PERIOD+1)-clock half period
  function automatic bit m_phase(input longint k);
    return anc_ph ^ bit'(((k - anc) / (longint'(m_per) + 1)) % 2);
  endfunction
  function automatic logic [31:0] m_out();
    return m_data & ~((EN && m_phase(n)) ? m_mask : 32'd0);
  endfunction
  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0: return m_data;
      3'd1: return EN ? m_mask : 32'd0;
      3'd2: return EN ? m_per : 32'd0;
      3'd3: return EN ? {31'd0, m_phase(n)} : 32'd0;
      3'd7: return m_out();
      default: return 32'd0;
    endcase
  endfunction
  task automatic m_reset();
    m_data = RV; m_mask = 0; m_per = PM; anc = n; anc_ph = 1'b0;
  endtask
  task automatic m_write(input logic [2:0] a, input logic [31:0] d);
    case (a)
      3'd0: m_data = d & WM;
      3'd1: if (EN) m_mask = d & WM;
      3'd2: if (EN) begin anc_ph = m_phase(n - 1); anc = n; m_per = d & PM; end
      3'd3: if (EN) begin anc_ph = 1'b0; anc = n; end
      3'd4: m_data = m_data | (d & WM);
      3'd5: m_data = m_data & ~d;
      3'd6: m_data = m_data ^ (d & WM);
      default: ;
    endcase
  endtask
  task automatic tick(input bit w, input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = w; bus.write_n = !w; bus.address = a; bus.writedata = d;
    @(posedge clk);
    n++;
    if (w) m_write(a, d);
    #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask
  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    check(tag, bus.readdata, exp);
  endtask
  task automatic check_all();
    logic [2:0] a;
    a = 3'($urandom_range(0, 7));
    check("out_port", 32'(out_port), m_out());
    rd_chk($sformatf("rd@%0d", a), a, m_rd(a));
  endtask
  initial begin
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = '0; bus.writedata = '0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_out_port", 32'(out_port), RV);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    m_reset();
    rd_chk("rst_rd0", 3'd0, 32'h0A5);
    rd_chk("rst_rd2", 3'd2, EN ? 32'h00FF_FFFF : 32'd0);
    rd_chk("rst_rd3", 3'd3, 32'd0);
    rd_chk("rst_rd1", 3'd1, 32'd0);
    rd_chk("rst_rd7", 3'd7, 32'h0A5);
    tick(1, ADDR_DATA, 32'hF0);
    check("data_f0", 32'(out_port), 32'hF0);
    tick(1, ADDR_OUTSET, 32'h0F);
    check("outset", 32'(out_port), 32'hFF);
    rd_chk("rd4", 3'd4, 32'd0);
    tick(1, ADDR_OUTCLEAR, 32'h30);
    check("outclear", 32'(out_port), 32'hCF);
    rd_chk("rd5", 3'd5, 32'd0);
    tick(1, ADDR_OUTTOGGLE, 32'h101);
    check("outtoggle", 32'(out_port), 32'h1CE);
    rd_chk("rd6", 3'd6, 32'd0);
    tick(1, ADDR_DATA, 32'h3);
    tick(1, ADDR_BLINK_MASK, 32'h1);
    tick(1, ADDR_PERIOD, 32'd3);
    tick(1, ADDR_STATUS, 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick(0, 3'd0, 32'd0);
      check("p3_out", 32'(out_port), m_out());
      rd_chk("p3_rd7", 3'd7, m_out());
      check("p3_bit1", 32'(out_port[1]), 32'd1);
    end
    tick(1, ADDR_DATA, 32'h1);
    tick(1, ADDR_PERIOD, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 3'd0, 32'd0);
      check_all();
    end
    tick(1, ADDR_STATUS, 32'h5A);
    rd_chk("st_phase0", 3'd3, 32'd0);
    check("st_out", 32'(out_port), 32'd1);
    tick(0, 3'd0, 32'd0);
    check("st_next", 32'(out_port), EN ? 32'd0 : 32'd1);
    tick(1, ADDR_PERIOD, 32'd100);
    tick(1, ADDR_STATUS, 32'd0);
    repeat (50) tick(0, 3'd0, 32'd0);
    tick(1, ADDR_PERIOD, 32'd10);
    repeat (10) tick(0, 3'd0, 32'd0);
    rd_chk("p10_before", 3'd3, 32'd0);
    tick(0, 3'd0, 32'd0);
    rd_chk("p10_toggle", 3'd3, EN ? 32'd1 : 32'd0);
    check_all();
    for (int i = 0; i < 400; i++) begin
      logic [2:0] a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = (a == ADDR_PERIOD) ? 32'($urandom_range(0, 7)) | 32'h8000_0000 : $urandom;
      tick($urandom_range(0, 1) == 1, a, d);
      check_all();
    end
    tick(1, ADDR_DATA, 32'h03FF_FFFF);
    tick(1, ADDR_BLINK_MASK, 32'h03FF_FFFF);
    tick(1, ADDR_PERIOD, 32'd2);
    tick(1, ADDR_STATUS, 32'd0);
    repeat (3) tick(0, 3'd0, 32'd0);
    check("blink_low", 32'(out_port), EN ? 32'd0 : 32'h03FF_FFFF);
    #2 reset_n = 1'b0;
    #1;
    check("async_out", 32'(out_port), RV);
    rd_chk("async_rd1", 3'd1, 32'd0);
    rd_chk("async_rd3", 3'd3, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    m_reset();
    rd_chk("rel_rd2", 3'd2, EN ? 32'h00FF_FFFF : 32'd0);
    tick(1, ADDR_BLINK_MASK, 32'hFFFF);
    rd_chk("mask_rd", 3'd1, EN ? 32'hFFFF : 32'd0);
    tick(1, ADDR_DATA, 32'h0012_3456);
    check("data_pins", 32'(out_port), 32'h0012_3456);
    for (int i = 0; i < 40; i++) begin
      tick(0, 3'd0, 32'd0);
      check_all();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_nios_pio_led_blink.md
# audio_nios_pio_led_blink

Parametrised Avalon-MM output PIO for the audio Nios subsystem, driving board LEDs or other static control lines. It is the successor to the fixed 26-bit LED PIO and adds atomic set/clear/toggle writes, a live output readback, and a per-bit hardware blink engine. Firmware can then flash status LEDs without polling. It sits on the Nios data master as a zero-wait-state slave, with `out_port` routed to the top-level LED pins.

## Interface
- `WIDTH`, default 26: number of output bits, legal range 1..32.
- `RESET_VALUE`, default 0: value of `data_out[WIDTH-1:0]` after reset.
- `PERIOD_W`, default 24: width of the blink half-period register, legal range 1..32.

Ports:
- `clk`, input, 1: single clock for the whole block.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `address`, input, 3: register select.
- `chipselect`, input, 1: slave select.
- `write_n`, input, 1: active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata`, input, 32: write data.
- `readdata`, output, 32: combinational read data, zero-extended.
- `out_port`, output, WIDTH: output pins.

## Operation
Register map (unused high bits read 0; writes to read-only locations are ignored):
- 0 DATA: R/W; a write loads `data_out` from `writedata[WIDTH-1:0]`.
- 1 BLINK_MASK: R/W, WIDTH bits; a 1 marks that bit as a blinking bit.
- 2 PERIOD: R/W, PERIOD_W bits; the blink half-period is PERIOD+1 clocks. A write also clears the counter to 0.
- 3 STATUS: a read returns bit0 = blink phase. A write of any value clears the counter and phase to 0.
- 4 OUTSET: write-only (reads 0); `data_out |= wd`.
- 5 OUTCLEAR: write-only (reads 0); `data_out &= ~wd`.
- 6 OUTTOGGLE: write-only (reads 0); `data_out ^= wd`.
- 7 OUTPORT: read-only; returns the live `out_port` value.

Blink engine:
- The free-running counter increments every clock.
- When counter == PERIOD, the counter wraps to 0 and the phase toggles.
- PERIOD = 0 makes the phase toggle every clock.
- Output function: `out_port[i] = data_out[i] & ~(blink_mask[i] & phase)`. A blinking bit whose DATA bit is 1 is driven high in phase 0 and low in phase 1.

Reset values:
- `data_out` = RESET_VALUE.
- BLINK_MASK = 0.
- PERIOD = all ones.
- Counter = 0, phase = 0.
- `out_port` = RESET_VALUE.

Boundary rules:
- Avalon allows only one write per cycle, so no two register writes can conflict.
- A STATUS write and a wrap in the same cycle: the write wins (counter 0, phase 0).
- A PERIOD write and a wrap in the same cycle: the counter goes to 0 and the phase does not toggle.
- A PERIOD write to a value below the current count takes effect from 0, so there is no long wrap-around.
- Reset asserted mid-blink returns all state to reset values immediately, asynchronously.

## Timing
- Writes are captured on the rising `clk` edge where `chipselect && !write_n`. `out_port` reflects the new value immediately after that edge (one-cycle write-to-pin latency).
- Reads are zero-wait: `readdata` is a combinational function of `address` and the registers. The read-data path depends only on `address`, not on `chipselect`.
- The phase toggles on the edge where the counter equals PERIOD. For a constant PERIOD, the blink period is 2×(PERIOD+1) clocks.
- `out_port` is combinational from registers only. It has no path from the bus inputs.

## Configuration
Macro: `AUDIO_NIOS_PIO_LED_BLINK_EN`.
- Defined: the blink engine, BLINK_MASK, PERIOD and STATUS are implemented as described above.
- Undefined:
  - The counter, phase, BLINK_MASK and PERIOD are not synthesised.
  - Addresses 1–3 read 0 and ignore writes.
  - `out_port = data_out`.
  - DATA, OUTSET, OUTCLEAR, OUTTOGGLE and OUTPORT behave identically to the defined case.

## Structure
- Package `audio_nios_pio_pkg` holds:
  - the address constants (ADDR_DATA = 0 … ADDR_OUTPORT = 7);
  - the address width of 3;
  - a function that builds the zero-extended 32-bit read word.
- Sub-module `audio_nios_pio_blink_timer` (PERIOD_W parameter):
  - inputs: `clk`, `reset_n`, `period`, `clr_cnt`, `clr_all`;
  - output: `phase`.
  - It is instantiated only under the macro.
- The top level holds the register file, the set/clear/toggle logic and the read mux.

## Test plan
1. Reset with WIDTH=26, RESET_VALUE=26'h0000_0A5 → `out_port` = 0x0A5, `readdata`@0 = 0x0A5, @2 = 0x00FF_FFFF, @3 = 0.
2. Write DATA = 0xF0, then OUTSET 0x0F, OUTCLEAR 0x30, OUTTOGGLE 0x101 → `out_port` = 0xFF, then 0xCF, then 0x1CE. Each value appears the cycle after its write; reads at addresses 4–6 return 0.
3. DATA = 0x3, BLINK_MASK = 0x1, PERIOD = 3 → bit0 toggles every 4 clocks (period 8) and bit1 stays at 1. Reading address 7 matches the pins.
4. PERIOD = 0 with BLINK_MASK = 0x1 and DATA = 0x1 → bit0 alternates every clock. A STATUS write on a wrap cycle → phase = 0 and counter = 0 on the next cycle.
5. PERIOD = 100, wait until count = 50, write PERIOD = 10 → the next toggle occurs 11 clocks after the write, not after a counter wrap-around.
6. Assert `reset_n` low asynchronously mid-blink, between clock edges → `out_port` goes to RESET_VALUE at once and BLINK_MASK reads 0. Rebuild without the macro → address 1 reads 0 after a write of 0xFFFF and `out_port` equals DATA.
